hilo_unit: RTL and testbench

- HI/LO special-register unit sitting directly downstream of the EX stage, and feeding back into it.
- Captures EX results (mult/div pair R1/R2, or mthi/mtlo operand RD1) and carries them through MEM and WB pipeline slots.
- Commits them to architectural HI/LO at WB.
- Drives forwarded HI/LO values back to the EX stage's HI/LO inputs so back-to-back mult/mfhi sequences see the newest value without stalling.

---
 rtl/hilo_unit_pkg.sv | 8 +
 rtl/hilo_unit_if.sv | 30 +++
 rtl/hilo_unit_slot.sv | 33 +++
 rtl/hilo_unit.sv | 72 +++++++
 tb/tb_hilo_unit.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/hilo_unit_pkg.sv
// Shared constants for the HI/LO special-register unit: operand-source
// encodings and the default data width.
package hilo_unit_pkg;
   localparam int HILO_WIDTH = 32;

   localparam logic HILO_SRC_ALU = 1'b0;
   localparam logic HILO_SRC_RD1 = 1'b1;
endpackage

// File: rtl/hilo_unit_if.sv
// EX-side bundle of the HI/LO unit: capture controls and data from EX,
// forwarded and committed HI/LO back out.
interface hilo_unit_if #(
   parameter int WIDTH = 32
);
   logic             stall_in;
   logic             flush_in;
   logic             ex_hi_we;
   logic             ex_lo_we;
   logic             ex_src;
   logic [WIDTH-1:0] R1;
   logic [WIDTH-1:0] R2;
   logic [WIDTH-1:0] RD1;
   logic [WIDTH-1:0] HI_fwd;
   logic [WIDTH-1:0] LO_fwd;
   logic [WIDTH-1:0] HI_arch;
   logic [WIDTH-1:0] LO_arch;

   // No valid/ready here: EX presents one instruction per unstalled cycle,
   // stall_in is the only back-pressure and flush_in kills the EX slot.
   modport master (
      output stall_in, flush_in, ex_hi_we, ex_lo_we, ex_src, R1, R2, RD1,
      input  HI_fwd, LO_fwd, HI_arch, LO_arch
   );

   modport slave (
      input  stall_in, flush_in, ex_hi_we, ex_lo_we, ex_src, R1, R2, RD1,
      output HI_fwd, LO_fwd, HI_arch, LO_arch
   );
endinterface

// File: rtl/hilo_unit_slot.sv
// One pipeline slot {hi_we, lo_we, hi_val, lo_val}: sync reset, hold and
// a kill input that turns the incoming entry into a bubble.
module hilo_unit_slot #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hold,
   input  logic             kill,
   input  logic             hi_we_d,
   input  logic             lo_we_d,
   input  logic [WIDTH-1:0] hi_val_d,
   input  logic [WIDTH-1:0] lo_val_d,
   output logic             hi_we,
   output logic             lo_we,
   output logic [WIDTH-1:0] hi_val,
   output logic [WIDTH-1:0] lo_val
);
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_we  <= 1'b0;
         lo_we  <= 1'b0;
         hi_val <= '0;
         lo_val <= '0;
      end else if (!hold) begin
         // Data still loads on a kill; only the write enables matter.
         hi_we  <= hi_we_d & ~kill;
         lo_we  <= lo_we_d & ~kill;
         hi_val <= hi_val_d;
         lo_val <= lo_val_d;
      end
   end
endmodule

// File: rtl/hilo_unit.sv
// HI/LO unit: MEM and WB slots behind EX, architectural HI/LO committed at
// WB, and youngest-first forwarding of HI/LO back into EX.
module hilo_unit
   import hilo_unit_pkg::*;
#(
   parameter int WIDTH = HILO_WIDTH
) (
   input logic          clk_in,
   input logic          rst_in,
   hilo_unit_if.slave   bus
);
   logic             hold;
   logic [WIDTH-1:0] cap_hi;
   logic [WIDTH-1:0] cap_lo;

   logic             mem_hi_we, mem_lo_we;
   logic [WIDTH-1:0] mem_hi_val, mem_lo_val;
   logic             wb_hi_we, wb_lo_we;
   logic [WIDTH-1:0] wb_hi_val, wb_lo_val;
   logic [WIDTH-1:0] hi_arch_q, lo_arch_q;

   // A flush must still drain the pipe, so it overrides a concurrent stall.
   assign hold   = bus.stall_in & ~bus.flush_in;
   assign cap_hi = (bus.ex_src == HILO_SRC_RD1) ? bus.RD1 : bus.R2;
   assign cap_lo = (bus.ex_src == HILO_SRC_RD1) ? bus.RD1 : bus.R1;

   hilo_unit_slot #(.WIDTH(WIDTH)) u_mem (
      .clk      (clk_in),
      .rst      (rst_in),
      .hold     (hold),
      .kill     (bus.flush_in),
      .hi_we_d  (bus.ex_hi_we),
      .lo_we_d  (bus.ex_lo_we),
      .hi_val_d (cap_hi),
      .lo_val_d (cap_lo),
      .hi_we    (mem_hi_we),
      .lo_we    (mem_lo_we),
      .hi_val   (mem_hi_val),
      .lo_val   (mem_lo_val)
   );

   hilo_unit_slot #(.WIDTH(WIDTH)) u_wb (
      .clk      (clk_in),
      .rst      (rst_in),
      .hold     (hold),
      .kill     (1'b0),
      .hi_we_d  (mem_hi_we),
      .lo_we_d  (mem_lo_we),
      .hi_val_d (mem_hi_val),
      .lo_val_d (mem_lo_val),
      .hi_we    (wb_hi_we),
      .lo_we    (wb_lo_we),
      .hi_val   (wb_hi_val),
      .lo_val   (wb_lo_val)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         hi_arch_q <= '0;
         lo_arch_q <= '0;
      end else if (!hold) begin
         if (wb_hi_we) hi_arch_q <= wb_hi_val;
         if (wb_lo_we) lo_arch_q <= wb_lo_val;
      end
   end

   // Youngest in-flight write wins, resolved per half; registered state only.
   assign bus.HI_fwd  = mem_hi_we ? mem_hi_val : (wb_hi_we ? wb_hi_val : hi_arch_q);
   assign bus.LO_fwd  = mem_lo_we ? mem_lo_val : (wb_lo_we ? wb_lo_val : lo_arch_q);
   assign bus.HI_arch = hi_arch_q;
   assign bus.LO_arch = lo_arch_q;
endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: directed scenarios with literal expectations, then a
// random run scored against a cycle model through an expected queue.
module tb_hilo_unit;
  localparam int W = 32;

  logic clk_in = 1'b0;
  logic rst_in;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [4*W-1:0] exp_q[$];

  // reference model state
  logic         m_mem_hw, m_mem_lw, m_wb_hw, m_wb_lw;
  logic [W-1:0] m_mem_hv, m_mem_lv, m_wb_hv, m_wb_lv, m_hi, m_lo;

  hilo_unit_if #(.WIDTH(W)) bus ();

  hilo_unit #(.WIDTH(W)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] hf, input logic [W-1:0] lf,
                           input logic [W-1:0] ha, input logic [W-1:0] la);
    check_eq({tag, ".HI_fwd"},  bus.HI_fwd,  hf);
    check_eq({tag, ".LO_fwd"},  bus.LO_fwd,  lf);
    check_eq({tag, ".HI_arch"}, bus.HI_arch, ha);
    check_eq({tag, ".LO_arch"}, bus.LO_arch, la);
  endtask

  // driver tasks
  task automatic drive(input logic st, input logic fl, input logic hw, input logic lw,
                       input logic src, input logic [W-1:0] r1, input logic [W-1:0] r2,
                       input logic [W-1:0] rd1);
    bus.stall_in = st;
    bus.flush_in = fl;
    bus.ex_hi_we = hw;
    bus.ex_lo_we = lw;
    bus.ex_src   = src;
    bus.R1       = r1;
    bus.R2       = r2;
    bus.RD1      = rd1;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom, $urandom, $urandom);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_edge();
    logic [W-1:0] hf, lf;
    if (rst_in) begin
      {m_mem_hw, m_mem_lw, m_wb_hw, m_wb_lw} = '0;
      {m_mem_hv, m_mem_lv, m_wb_hv, m_wb_lv, m_hi, m_lo} = '0;
    end else if (!bus.stall_in || bus.flush_in) begin
      if (m_wb_hw) m_hi = m_wb_hv;
      if (m_wb_lw) m_lo = m_wb_lv;
      {m_wb_hw, m_wb_lw, m_wb_hv, m_wb_lv} = {m_mem_hw, m_mem_lw, m_mem_hv, m_mem_lv};
      m_mem_hw = bus.ex_hi_we && !bus.flush_in;
      m_mem_lw = bus.ex_lo_we && !bus.flush_in;
      m_mem_hv = bus.ex_src ? bus.RD1 : bus.R2;
      m_mem_lv = bus.ex_src ? bus.RD1 : bus.R1;
    end
    hf = m_mem_hw ? m_mem_hv : (m_wb_hw ? m_wb_hv : m_hi);
    lf = m_mem_lw ? m_mem_lv : (m_wb_lw ? m_wb_lv : m_lo);
    exp_q.push_back({hf, lf, m_hi, m_lo});
  endtask

  initial begin
    logic [4*W-1:0] e;
    rst_in = 1'b1;
    bubble();

    // reset with random inputs on the bus
    for (int i = 0; i < 2; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), 1'b1, 1'b1, $urandom_range(0, 1),
            $urandom, $urandom, $urandom);
      step();
    end
    check_all("reset", '0, '0, '0, '0);
    rst_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bubble();
      step();
      check_all("post_reset", '0, '0, '0, '0);
    end

    // mult commit
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0006, 32'h0000_0001, $urandom);
    step();
    check_all("mult_t1", 32'h1, 32'h6, 32'h0, 32'h0);
    bubble();
    step();
    check_all("mult_t2", 32'h1, 32'h6, 32'h0, 32'h0);
    bubble();
    step();
    check_all("mult_t3", 32'h1, 32'h6, 32'h1, 32'h6);

    // mult then mthi: youngest write wins per half
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, $urandom);
    step();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, $urandom, $urandom, 32'h1234_5678);
    step();
    check_all("prio_t2", 32'h1234_5678, 32'hAAAA_AAAA, 32'h1, 32'h6);
    bubble();
    step();
    check_all("prio_t3", 32'h1234_5678, 32'hAAAA_AAAA, 32'h5555_5555, 32'hAAAA_AAAA);
    step();
    check_all("prio_fin", 32'h1234_5678, 32'hAAAA_AAAA, 32'h1234_5678, 32'hAAAA_AAAA);

    // stall hold with a mult in MEM
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0007, 32'h0000_0009, $urandom);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, $urandom, $urandom, $urandom);
      step();
      check_all("stall", 32'h9, 32'h7, 32'h1234_5678, 32'hAAAA_AAAA);
    end
    bubble();
    step();
    check_all("unstall_1", 32'h9, 32'h7, 32'h1234_5678, 32'hAAAA_AAAA);
    step();
    check_all("unstall_2", 32'h9, 32'h7, 32'h9, 32'h7);

    // flush: killed mtlo never becomes visible
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, $urandom, $urandom, 32'hDEAD_BEEF);
    step();
    for (int i = 0; i < 3; i++) begin
      check_all("flush", 32'h9, 32'h7, 32'h9, 32'h7);
      bubble();
      step();
    end

    // flush with stall: pipe still advances, mult commits, mtlo killed
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0011, 32'h0000_0022, $urandom);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, $urandom, $urandom, 32'hDEAD_BEEF);
    step();
    check_all("flush_stall_t1", 32'h22, 32'h11, 32'h9, 32'h7);
    bubble();
    step();
    check_all("flush_stall_t2", 32'h22, 32'h11, 32'h22, 32'h11);
    step();
    check_all("flush_stall_t3", 32'h22, 32'h11, 32'h22, 32'h11);

    // reset mid-flight discards the mult
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0033, 32'h0000_0044, $urandom);
    step();
    rst_in = 1'b1;
    bubble();
    step();
    rst_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bubble();
      step();
      check_all("rst_mid", '0, '0, '0, '0);
    end

    // random run against the model; model starts from the reset state
    rst_in = 1'b1;
    bubble();
    model_edge();
    step();
    e = exp_q.pop_front();
    check_all("rand_rst", e[4*W-1:3*W], e[3*W-1:2*W], e[2*W-1:W], e[W-1:0]);
    for (int i = 0; i < 300; i++) begin
      rst_in = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom, $urandom, $urandom);
      model_edge();
      step();
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rand_q: expected queue empty at cycle %0d", i);
      end else begin
        e = exp_q.pop_front();
        check_all("rand", e[4*W-1:3*W], e[3*W-1:2*W], e[2*W-1:W], e[W-1:0]);
      end
    end

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
